// File: rtl/kurm_multicycle_sequencer.sv
// rtl/kurm_multicycle_sequencer.sv - KURM multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer
module kurm_multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             alu_zero,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             alu_en,
    output logic [2:0]       alu_op,
    output logic             alu_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd7
    } state_t;

    state_t           st;
    state_t           st_nxt;
    state_t           retire_to;
    logic [3:0]       op_q;
    logic [3:0]       op_d;
    logic [TW-1:0]    tcnt;
    logic [1:0]       code_q;
    logic [CNT_W-1:0] ret_q;
    logic             expired;
    logic             is_rtype;
    logic             is_lw;
    logic             is_sw;
    logic             is_bne;
    logic             is_jmp;
    logic             is_ill;

    // The opcode is only latched at the end of DECODE, so DECODE itself looks at the live input.
    assign op_d     = (st == S_DECODE) ? opcode : op_q;
    assign is_rtype = (op_d <= 4'd4) || (op_d == 4'd9);
    assign is_lw    = (op_d == 4'd5);
    assign is_sw    = (op_d == 4'd6);
    assign is_bne   = (op_d == 4'd7);
    assign is_jmp   = (op_d == 4'd8);
    assign is_ill   = (op_d >= 4'd10);

    // Last allowed cycle without ack; an ack in this same cycle still wins.
    assign expired   = (tcnt == TW'(MEM_TIMEOUT - 1));
    assign retire_to = run ? S_FETCH : S_IDLE;

    assign state      = st;
    assign retired    = ret_q;
    assign fault      = (st == S_TRAP);
    assign fault_code = code_q;

    always_comb begin
        st_nxt     = st;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_en     = 1'b0;
        alu_op     = 3'b000;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        case (st)
            S_IDLE: begin
                if (run) st_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    st_nxt  = S_DECODE;
                end else if (expired) begin
                    st_nxt = S_TRAP;
                end
            end
            S_DECODE: begin
                if (is_ill) begin
                    st_nxt = S_TRAP;
                end else if (is_jmp) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    st_nxt   = retire_to;
                end else begin
                    st_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_en  = 1'b1;
                alu_src = is_lw | is_sw;
                if (op_d <= 4'd4)  alu_op = op_d[2:0];
                else if (is_bne)   alu_op = 3'b001;
                else               alu_op = 3'b101;
                if (is_bne) begin
                    pc_write = 1'b1;
                    pc_src   = alu_zero ? 2'd0 : 2'd1;
                    st_nxt   = retire_to;
                end else if (is_lw || is_sw) begin
                    st_nxt = S_MEM;
                end else if (is_rtype) begin
                    st_nxt = S_WRITEBACK;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ack) begin
                    if (is_sw) begin
                        pc_write = 1'b1;
                        st_nxt   = retire_to;
                    end else begin
                        st_nxt = S_WRITEBACK;
                    end
                end else if (expired) begin
                    st_nxt = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                reg_write  = 1'b1;
                reg_dst    = ~is_lw;
                mem_to_reg = is_lw;
                pc_write   = 1'b1;
                st_nxt     = retire_to;
            end
            S_TRAP: begin
                st_nxt = S_TRAP;
            end
            default: begin
                st_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            st     <= S_IDLE;
            op_q   <= 4'd0;
            tcnt   <= '0;
            code_q <= 2'd0;
            ret_q  <= '0;
        end else begin
            st <= st_nxt;
            if (st == S_DECODE) op_q <= opcode;
            // Any state change restarts the wait count; staying in FETCH/MEM means no ack arrived.
            if (st_nxt != st) begin
                tcnt <= '0;
            end else if (st == S_FETCH || st == S_MEM) begin
                tcnt <= tcnt + 1'b1;
            end
            if (st_nxt == S_TRAP && st != S_TRAP) begin
                if (st == S_DECODE)     code_q <= 2'd1;
                else if (st == S_FETCH) code_q <= 2'd2;
                else                    code_q <= 2'd3;
            end
            if (pc_write) ret_q <= ret_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_kurm_multicycle_sequencer.sv
// tb/tb_kurm_multicycle_sequencer.sv - randomized instruction-level check of kurm_multicycle_sequencer
module tb_kurm_multicycle_sequencer;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;

    logic             clock = 1'b0;
    logic             reset_n, run, imem_ack, dmem_ack, alu_zero;
    logic [3:0]       opcode;
    logic             imem_req, ir_load, dmem_req, dmem_we, alu_en, alu_src;
    logic             reg_dst, mem_to_reg, reg_write, pc_write, fault;
    logic [2:0]       alu_op, state;
    logic [1:0]       pc_src, fault_code;
    logic [CNT_W-1:0] retired;

    kurm_multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .alu_en(alu_en), .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_write(pc_write),
        .pc_src(pc_src), .state(state), .retired(retired), .fault(fault),
        .fault_code(fault_code)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic             e_imreq, e_irl, e_dreq, e_dwe, e_aen, e_asrc, e_rdst, e_m2r, e_rw, e_pcw, e_flt;
    logic [2:0]       e_aop, e_st;
    logic [1:0]       e_pcs, e_fc;
    logic [CNT_W-1:0] exp_ret = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({imem_req, ir_load, dmem_req, dmem_we, alu_en, alu_op, alu_src, reg_dst,
                    mem_to_reg, reg_write, pc_write, pc_src, state, fault, fault_code});
    endfunction

    function automatic logic [31:0] exp_vec();
        return 32'({e_imreq, e_irl, e_dreq, e_dwe, e_aen, e_aop, e_asrc, e_rdst,
                    e_m2r, e_rw, e_pcw, e_pcs, e_st, e_flt, e_fc});
    endfunction

    task automatic clr_exp();
        {e_imreq, e_irl, e_dreq, e_dwe, e_aen, e_asrc, e_rdst, e_m2r, e_rw, e_pcw, e_flt} = '0;
        e_aop = 3'd0; e_st = 3'd0; e_pcs = 2'd0; e_fc = 2'd0;
    endtask

    // Random values on every input; callers then pin the ones that matter this cycle.
    task automatic noise();
        run      = 1'($urandom);
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        alu_zero = 1'($urandom);
        opcode   = 4'($urandom);
    endtask

    task automatic step(input string tag);
        @(negedge clock);
        check({tag, "/outputs"}, out_vec(), exp_vec());
        check({tag, "/retired"}, 32'(retired), 32'(exp_ret));
        @(posedge clock);
        if (!reset_n) exp_ret = '0;
        else if (e_pcw) exp_ret = exp_ret + 1'b1;
        #1;
    endtask

    task automatic post_reset();
        reset_n = 1'b1;
        noise();
        run = 1'b0;
        clr_exp();
        step("post_reset");
    endtask

    task automatic trap_check(input logic [1:0] code);
        repeat (3) begin
            noise();
            clr_exp(); e_st = 3'd7; e_flt = 1'b1; e_fc = code;
            step("trap");
        end
        reset_n = 1'b0;
        noise();
        clr_exp(); e_st = 3'd7; e_flt = 1'b1; e_fc = code;
        step("trap_reset");
        post_reset();
    endtask

    // One instruction from FETCH entry to retire, trap or reset; ended=1 means the DUT is back in IDLE via reset.
    task automatic instr(input logic [3:0] op, input int di, input int dd, input logic run_after,
                         input int rst_mem, output logic ended);
        logic acked;
        ended = 1'b0;
        acked = 1'b0;
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            noise();
            imem_ack = (k == di);
            clr_exp(); e_st = 3'd1; e_imreq = 1'b1; e_irl = imem_ack;
            step("fetch");
            if (k == di) begin acked = 1'b1; break; end
        end
        if (!acked) begin trap_check(2'd2); ended = 1'b1; return; end

        noise();
        opcode = op;
        clr_exp(); e_st = 3'd2;
        if (op == 4'd8) begin run = run_after; e_pcw = 1'b1; e_pcs = 2'd2; end
        step("decode");
        if (op >= 4'd10) begin trap_check(2'd1); ended = 1'b1; return; end
        if (op == 4'd8) return;

        noise();
        clr_exp(); e_st = 3'd3; e_aen = 1'b1;
        e_aop  = (op <= 4'd4) ? op[2:0] : (op == 4'd7) ? 3'b001 : 3'b101;
        e_asrc = (op == 4'd5) || (op == 4'd6);
        if (op == 4'd7) begin run = run_after; e_pcw = 1'b1; e_pcs = alu_zero ? 2'd0 : 2'd1; end
        step("execute");
        if (op == 4'd7) return;

        if (op == 4'd5 || op == 4'd6) begin
            acked = 1'b0;
            for (int k = 0; k < MEM_TIMEOUT; k++) begin
                noise();
                dmem_ack = (k == dd);
                if (k == rst_mem) begin reset_n = 1'b0; dmem_ack = 1'b0; end
                clr_exp(); e_st = 3'd4; e_dreq = 1'b1; e_dwe = (op == 4'd6);
                if (dmem_ack && op == 4'd6) begin run = run_after; e_pcw = 1'b1; end
                step("mem");
                if (!reset_n) begin post_reset(); ended = 1'b1; return; end
                if (dmem_ack) begin acked = 1'b1; break; end
            end
            if (!acked) begin trap_check(2'd3); ended = 1'b1; return; end
            if (op == 4'd6) return;
        end

        noise();
        run = run_after;
        clr_exp(); e_st = 3'd5; e_rw = 1'b1; e_rdst = (op != 4'd5); e_m2r = (op == 4'd5); e_pcw = 1'b1;
        step("writeback");
    endtask

    function automatic int pick_delay();
        int r = int'($urandom_range(0, 19));
        if (r == 0) return MEM_TIMEOUT + int'($urandom_range(0, 1));
        if (r == 1) return MEM_TIMEOUT - 1;
        return int'($urandom_range(0, 2));
    endfunction

    int   t_op  [9] = '{0, 5, 7, 6, 12, 0, 0, 5, 6};
    int   t_di  [9] = '{0, 0, 0, 0, 0, 14, 15, 0, 0};
    int   t_dd  [9] = '{0, 3, 0, 1, 0, 0, 0, 4, 15};
    int   t_run [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    int   t_rst [9] = '{-1, -1, -1, -1, -1, -1, -1, 2, -1};

    initial begin
        logic       in_idle;
        logic       ended;
        logic [3:0] op;
        int         di, dd, rm;
        logic       ra;

        reset_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0; opcode = 4'd0;
        @(posedge clock); #1;
        run = 1'b1; imem_ack = 1'b1;
        clr_exp();
        step("reset");
        post_reset();
        in_idle = 1'b1;

        for (int i = 0; i < 220; i++) begin
            if (in_idle) begin
                repeat ($urandom_range(0, 2)) begin
                    noise(); run = 1'b0; clr_exp(); step("idle");
                end
                noise(); run = 1'b1; clr_exp(); step("idle_go");
            end
            if (i < 9) begin
                op = 4'(t_op[i]); di = t_di[i]; dd = t_dd[i]; ra = 1'(t_run[i]); rm = t_rst[i];
            end else begin
                op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                di = pick_delay();
                dd = pick_delay();
                ra = ($urandom_range(0, 3) != 0);
                rm = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 2)) : -1;
            end
            instr(op, di, dd, ra, rm, ended);
            in_idle = ended || !ra;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
